alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//   Front-end stage that feeds the multi-cycle alu. Accepts a whole command (op, A, B) from the host
//   over a valid/ready handshake and serialises it onto the alu's byte port: A with alu_valid, then B.
//   Collects the 1- or 2-byte result from alu_o on alu_ready pulses and presents it to the host as
//   one 16-bit word. A watchdog flags an alu that never answers.
// PARAMETERS
//   DATA_W   8        alu operand/byte width (result word is 2*DATA_W)
//   TIMEOUT  64       max cycles in a wait state before abort with error (>=2)
//   WIDE_OPS 4'b1100  bit n set => op code n returns two bytes (hi first); 10=mul, 11=div
// PORTS
//   clk          in   1         rising-edge clock
//   rst          in   1         async active-low reset
//   cmd_valid    in   1         host command present
//   cmd_ready    out  1         sequencer can take a command (IDLE only)
//   cmd_op       in   2         op code, passed to alu_op_codes
//   cmd_a        in   DATA_W    operand A
//   cmd_b        in   DATA_W    operand B
//   res_valid    out  1         result word held for host
//   res_ready    in   1         host accepts result
//   res_data     out  2*DATA_W  result; narrow ops zero-extended {0,lo}
//   res_err      out  1         qualifies res_valid: watchdog expired, res_data=0
//   busy         out  1         high in every state except IDLE
//   alu_in       out  DATA_W    alu byte input
//   alu_op_codes out  2         alu op select, stable from SEND_A through result
//   alu_valid    out  1         one-cycle start strobe to alu (with A)
//   alu_o        in   DATA_W    alu result byte
//   alu_ready    in   1         alu result-byte strobe, one cycle per byte
// BEHAVIOUR
//   Reset (rst=0, async): state IDLE; all outputs 0 except cmd_ready=1; latched op/A/B, timer cleared.
//   States: IDLE, SEND_A, SEND_B, WAIT_HI, WAIT_LO, DONE. All outputs registered.
//   IDLE: cmd_ready=1. cmd_valid&cmd_ready latches op/A/B -> SEND_A.
//   SEND_A (1 cyc): alu_valid=1, alu_in=A, alu_op_codes=op -> SEND_B.
//   SEND_B (1 cyc): alu_valid=0, alu_in=B -> WAIT_HI if WIDE_OPS[op] else WAIT_LO; timer=0.
//   WAIT_HI: on alu_ready capture res_data[15:8]=alu_o -> WAIT_LO, timer=0.
//   WAIT_LO: on alu_ready capture res_data[7:0]=alu_o (narrow: [15:8]=0) -> DONE.
//   Back-to-back alu_ready in consecutive cycles (hi then lo) must both be captured.
//   alu_ready in IDLE/SEND_A/SEND_B/DONE ignored, no state change.
//   Watchdog: timer increments each WAIT_* cycle without alu_ready; reaching TIMEOUT-1 ->
//     DONE with res_err=1, res_data=0. Timer saturates, never wraps.
//   DONE: res_valid=1, data/err stable until res_valid&res_ready -> IDLE (res_valid, res_err
//     drop next cycle). Host stall holds DONE indefinitely; watchdog inactive.
//   Latency, narrow op, alu answers k cycles after B: cmd accept -> res_valid = 3+k cycles.
//   cmd_valid while busy: cmd_ready=0, command not taken, no latch disturbed.
//   alu_in holds B after SEND_B until next SEND_A; alu_op_codes holds op until next command.
//   Reset mid-operation (any state): immediate IDLE, partial result discarded, alu_valid=0.
// TESTING
//   1 op=00 A=10 B=5, alu_ready+alu_o=15 after 4 cyc -> alu_valid 1 cyc w/ in=10, then in=5;
//     res_data=16'h000F, res_err=0.
//   2 op=10 A=10 B=5, alu_ready pulses hi=8'h00 then lo=8'h32 back-to-back -> res_data=16'h0032.
//   3 op=11, alu_ready never -> res_valid with res_err=1, res_data=0 at TIMEOUT cyc after SEND_B.
//   4 res_ready held 0 for 10 cyc in DONE; cmd_valid pulsed meanwhile -> data stable,
//     cmd_ready=0, second command accepted only after handshake.
//   5 rst=0 in WAIT_LO of wide op -> all outputs reset immediately; next op=01 A=9 B=3
//     (alu_o=6) returns 16'h0006 with no stale hi byte.
//   6 spurious alu_ready during SEND_A/SEND_B -> ignored; correct result captured later.

Source files
------------

// File: rtl/alu_cmd_sequencer_if.sv
// Host command/result handshake and alu byte-port signals of the alu command sequencer.
// The sequencer uses the slave view; whoever drives the host and alu sides uses master.
interface alu_cmd_sequencer_if #(
    parameter int DATA_W = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [DATA_W-1:0]     cmd_a;
    logic [DATA_W-1:0]     cmd_b;
    logic                  res_valid;
    logic                  res_ready;
    logic [2*DATA_W-1:0]   res_data;
    logic                  res_err;
    logic                  busy;
    logic [DATA_W-1:0]     alu_in;
    logic [1:0]            alu_op_codes;
    logic                  alu_valid;
    logic [DATA_W-1:0]     alu_o;
    logic                  alu_ready;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, res_ready, alu_o, alu_ready,
        output cmd_ready, res_valid, res_data, res_err, busy, alu_in, alu_op_codes, alu_valid
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, res_ready, alu_o, alu_ready,
        input  cmd_ready, res_valid, res_data, res_err, busy, alu_in, alu_op_codes, alu_valid
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Serialises a host command (op, A, B) onto the multi-cycle alu byte port and collects its
// 1- or 2-byte answer into one result word; a watchdog aborts waits the alu never answers.
module alu_cmd_sequencer #(
    parameter int         DATA_W   = 8,
    parameter int         TIMEOUT  = 64,
    parameter logic [3:0] WIDE_OPS = 4'b1100
) (
    input logic                clk_i,
    input logic                rst_ni,
    alu_cmd_sequencer_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND_A,
        SEND_B,
        WAIT_HI,
        WAIT_LO,
        DONE
    } state_e;

    state_e                state_q;
    logic [TW-1:0]         timer_q;
    logic [TW-1:0]         timer_d;
    logic [DATA_W-1:0]     b_q;
    logic                  cmd_ready_q;
    logic                  busy_q;
    logic                  alu_valid_q;
    logic [DATA_W-1:0]     alu_in_q;
    logic [1:0]            alu_op_q;
    logic                  res_valid_q;
    logic                  res_err_q;
    logic [2*DATA_W-1:0]   res_data_q;

    // Saturating so a stuck wait can never wrap back into a fresh window.
    always_comb begin
        timer_d = timer_q;
        if (timer_q != TIMER_LAST) begin
            timer_d = timer_q + TW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            b_q         <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            alu_valid_q <= 1'b0;
            alu_in_q    <= '0;
            alu_op_q    <= '0;
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
            res_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        state_q     <= SEND_A;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        alu_valid_q <= 1'b1;
                        alu_in_q    <= bus.cmd_a;
                        alu_op_q    <= bus.cmd_op;
                        b_q         <= bus.cmd_b;
                        res_data_q  <= '0;
                    end
                end
                SEND_A: begin
                    state_q     <= SEND_B;
                    alu_valid_q <= 1'b0;
                    alu_in_q    <= b_q;
                end
                SEND_B: begin
                    timer_q <= '0;
                    state_q <= WIDE_OPS[alu_op_q] ? WAIT_HI : WAIT_LO;
                end
                WAIT_HI: begin
                    if (bus.alu_ready) begin
                        res_data_q[2*DATA_W-1:DATA_W] <= bus.alu_o;
                        timer_q <= '0;
                        state_q <= WAIT_LO;
                    end else if (timer_q == TIMER_LAST) begin
                        state_q     <= DONE;
                        res_valid_q <= 1'b1;
                        res_err_q   <= 1'b1;
                        res_data_q  <= '0;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                WAIT_LO: begin
                    // alu_ready wins over an expiring watchdog in the same cycle.
                    if (bus.alu_ready) begin
                        res_data_q  <= {(WIDE_OPS[alu_op_q] ? res_data_q[2*DATA_W-1:DATA_W]
                                                            : DATA_W'(0)), bus.alu_o};
                        res_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (timer_q == TIMER_LAST) begin
                        state_q     <= DONE;
                        res_valid_q <= 1'b1;
                        res_err_q   <= 1'b1;
                        res_data_q  <= '0;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        state_q     <= IDLE;
                        res_valid_q <= 1'b0;
                        res_err_q   <= 1'b0;
                        res_data_q  <= '0;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    alu_valid_q <= 1'b0;
                    res_valid_q <= 1'b0;
                    res_err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready    = cmd_ready_q;
    assign bus.busy         = busy_q;
    assign bus.alu_valid    = alu_valid_q;
    assign bus.alu_in       = alu_in_q;
    assign bus.alu_op_codes = alu_op_q;
    assign bus.res_valid    = res_valid_q;
    assign bus.res_err      = res_err_q;
    assign bus.res_data     = res_data_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: directed scenarios plus randomized commands whose
// result and arrival cycle are predicted from per-command alu answer schedules.
module tb_alu_cmd_sequencer;
    localparam int         DW   = 8;
    localparam int         T    = 8;
    localparam logic [3:0] WIDE = 4'b1100;

    logic clk    = 1'b0;
    logic rst_ni = 1'b0;
    int   checks = 0;
    int   errors = 0;

    alu_cmd_sequencer_if #(.DATA_W(DW)) bus ();

    alu_cmd_sequencer #(
        .DATA_W  (DW),
        .TIMEOUT (T),
        .WIDE_OPS(WIDE)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Appends one alu answer phase: d idle cycles then a ready strobe, or a full silent window.
    task automatic pushPhase(input int d, input logic [7:0] val, inout bit rdyQ[$],
                             inout logic [7:0] datQ[$], inout bit err);
        if (d >= T) begin
            for (int i = 0; i < T; i++) begin
                rdyQ.push_back(1'b0);
                datQ.push_back(8'($urandom));
            end
            err = 1'b1;
        end else begin
            for (int i = 0; i < d; i++) begin
                rdyQ.push_back(1'b0);
                datQ.push_back(8'($urandom));
            end
            rdyQ.push_back(1'b1);
            datQ.push_back(val);
        end
    endtask

    // One full command from IDLE back to IDLE; the alu side follows a precomputed schedule.
    task automatic applyStimulus(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input int dHi, input logic [7:0] hi,
                                 input int dLo, input logic [7:0] lo,
                                 input bit spurious, input int stall, input bit pulseCmd);
        bit          rdyQ[$];
        logic [7:0]  datQ[$];
        bit          err;
        bit          wide;
        logic [3:0]  wideMask;
        logic [15:0] expData;

        wideMask = WIDE;
        wide     = wideMask[op];
        err      = 1'b0;
        if (wide) pushPhase(dHi, hi, rdyQ, datQ, err);
        if (!err) pushPhase(dLo, lo, rdyQ, datQ, err);
        expData = err ? 16'h0000 : (wide ? {hi, lo} : {8'h00, lo});

        checkOutput("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        checkOutput("idle_busy", 32'(bus.busy), 32'd0);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.res_ready = 1'b0;
        bus.alu_ready = 1'b0;
        @(posedge clk); #1;

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'($urandom);
        bus.cmd_a     = 8'($urandom);
        bus.cmd_b     = 8'($urandom);
        checkOutput("send_a_valid", 32'(bus.alu_valid), 32'd1);
        checkOutput("send_a_in", 32'(bus.alu_in), 32'(a));
        checkOutput("send_a_op", 32'(bus.alu_op_codes), 32'(op));
        checkOutput("send_a_busy", 32'(bus.busy), 32'd1);
        checkOutput("send_a_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        bus.alu_ready = spurious;
        bus.alu_o     = 8'($urandom);
        @(posedge clk); #1;

        checkOutput("send_b_valid", 32'(bus.alu_valid), 32'd0);
        checkOutput("send_b_in", 32'(bus.alu_in), 32'(b));
        checkOutput("send_b_res_valid", 32'(bus.res_valid), 32'd0);
        bus.alu_ready = spurious;
        bus.alu_o     = 8'($urandom);
        @(posedge clk); #1;

        for (int i = 0; i < rdyQ.size(); i++) begin
            checkOutput("wait_res_valid", 32'(bus.res_valid), 32'd0);
            bus.alu_ready = rdyQ[i];
            bus.alu_o     = datQ[i];
            @(posedge clk); #1;
        end
        bus.alu_ready = 1'b0;

        checkOutput("done_res_valid", 32'(bus.res_valid), 32'd1);
        checkOutput("done_res_err", 32'(bus.res_err), 32'(err));
        checkOutput("done_res_data", 32'(bus.res_data), 32'(expData));
        checkOutput("done_busy", 32'(bus.busy), 32'd1);
        checkOutput("done_alu_in_holds_b", 32'(bus.alu_in), 32'(b));
        checkOutput("done_op_holds", 32'(bus.alu_op_codes), 32'(op));

        for (int j = 0; j < stall; j++) begin
            if (pulseCmd && j == 0) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_op    = ~op;
                bus.cmd_a     = 8'($urandom);
                bus.cmd_b     = 8'($urandom);
            end
            bus.alu_ready = 1'($urandom);
            bus.alu_o     = 8'($urandom);
            checkOutput("stall_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            @(posedge clk); #1;
            bus.cmd_valid = 1'b0;
            checkOutput("stall_res_valid", 32'(bus.res_valid), 32'd1);
            checkOutput("stall_res_data", 32'(bus.res_data), 32'(expData));
            checkOutput("stall_res_err", 32'(bus.res_err), 32'(err));
        end
        bus.alu_ready = 1'b0;

        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        checkOutput("ack_res_valid", 32'(bus.res_valid), 32'd0);
        checkOutput("ack_res_err", 32'(bus.res_err), 32'd0);
        checkOutput("ack_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        checkOutput("ack_busy", 32'(bus.busy), 32'd0);
        checkOutput("ack_op_holds", 32'(bus.alu_op_codes), 32'(op));
    endtask

    task automatic checkResetOutputs(input string phase);
        checkOutput({phase, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        checkOutput({phase, "_busy"}, 32'(bus.busy), 32'd0);
        checkOutput({phase, "_alu_valid"}, 32'(bus.alu_valid), 32'd0);
        checkOutput({phase, "_alu_in"}, 32'(bus.alu_in), 32'd0);
        checkOutput({phase, "_alu_op"}, 32'(bus.alu_op_codes), 32'd0);
        checkOutput({phase, "_res_valid"}, 32'(bus.res_valid), 32'd0);
        checkOutput({phase, "_res_err"}, 32'(bus.res_err), 32'd0);
        checkOutput({phase, "_res_data"}, 32'(bus.res_data), 32'd0);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_a     = 8'h00;
        bus.cmd_b     = 8'h00;
        bus.res_ready = 1'b0;
        bus.alu_o     = 8'h00;
        bus.alu_ready = 1'b0;

        #12;
        checkResetOutputs("reset");
        rst_ni = 1'b1;
        @(posedge clk); #1;

        // Narrow add answered after a few idle cycles.
        applyStimulus(2'b00, 8'd10, 8'd5, 0, 8'h00, 3, 8'd15, 1'b0, 0, 1'b0);
        // Wide mul with hi and lo strobes in consecutive cycles.
        applyStimulus(2'b10, 8'd10, 8'd5, 0, 8'h00, 0, 8'h32, 1'b0, 0, 1'b0);
        // Wide div the alu never answers.
        applyStimulus(2'b11, 8'h20, 8'h04, T, 8'h00, 0, 8'h00, 1'b0, 0, 1'b0);
        // Host stalls ten cycles while a second command is offered.
        applyStimulus(2'b01, 8'd7, 8'd2, 0, 8'h00, 2, 8'h55, 1'b0, 10, 1'b1);
        applyStimulus(2'b10, 8'hA5, 8'h3C, 1, 8'h12, 2, 8'h34, 1'b0, 0, 1'b0);
        // Stray alu_ready strobes while A and B are being sent.
        applyStimulus(2'b00, 8'd3, 8'd4, 0, 8'h00, 1, 8'h07, 1'b1, 0, 1'b0);
        applyStimulus(2'b11, 8'd3, 8'd4, 2, 8'hBE, 0, 8'hEF, 1'b1, 2, 1'b0);
        // Watchdog edges: last accepted cycle versus first expired one.
        applyStimulus(2'b00, 8'd1, 8'd2, 0, 8'h00, T - 1, 8'h77, 1'b0, 0, 1'b0);
        applyStimulus(2'b01, 8'd1, 8'd2, 0, 8'h00, T, 8'h77, 1'b0, 0, 1'b0);
        applyStimulus(2'b10, 8'd1, 8'd2, T - 1, 8'hC3, T - 1, 8'h3C, 1'b0, 0, 1'b0);
        applyStimulus(2'b10, 8'd1, 8'd2, 0, 8'hC3, T, 8'h3C, 1'b0, 1, 1'b0);

        // Reset asserted mid-cycle while a wide op waits for its low byte.
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b10;
        bus.cmd_a     = 8'd50;
        bus.cmd_b     = 8'd60;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.alu_ready = 1'b1;
        bus.alu_o     = 8'hAB;
        @(posedge clk); #1;
        bus.alu_ready = 1'b0;
        checkOutput("pre_reset_busy", 32'(bus.busy), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        checkResetOutputs("midop_reset");
        @(posedge clk); #1;
        rst_ni = 1'b1;
        @(posedge clk); #1;
        applyStimulus(2'b01, 8'd9, 8'd3, 0, 8'h00, 0, 8'd6, 1'b0, 0, 1'b0);

        // Randomized commands, occasionally straddling the watchdog limit.
        for (int n = 0; n < 40; n++) begin
            int dh;
            int dl;
            dh = ($urandom_range(0, 7) == 0) ? int'($urandom_range(T - 1, T + 1))
                                             : int'($urandom_range(0, 4));
            dl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(T - 1, T + 1))
                                             : int'($urandom_range(0, 4));
            applyStimulus(2'($urandom), 8'($urandom), 8'($urandom), dh, 8'($urandom),
                          dl, 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                          1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
